// File: rtl/decoder_scan_nx.sv
// Registered N-to-2^N one-hot decoder with manual decode and auto-scan modes.
// Optional feature: define DECODER_SCAN_DEADTIME_EN to blank Out for one cycle on every scan step.
module decoder_scan_nx #(
  parameter int N   = 2,
  parameter int DIV = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                mode,
  input  logic [N-1:0]        In,
  output logic [(1<<N)-1:0]   Out,
  output logic [N-1:0]        index,
  output logic                wrap
);

  localparam int LINES = 1 << N;
  localparam int PW    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);
  localparam logic [N-1:0]  IDX_LAST = N'(LINES - 1);

  logic [PW-1:0]    pre_r;
  logic [PW-1:0]    pre_nxt_s;
  logic [N-1:0]     idx_r;
  logic [N-1:0]     idx_nxt_s;
  logic [LINES-1:0] out_r;
  logic [LINES-1:0] out_nxt_s;
  logic             wrap_r;
  logic             wrap_nxt_s;

  function automatic logic [LINES-1:0] onehot(input logic [N-1:0] sel);
    logic [LINES-1:0] v;
    v = {LINES{1'b0}};
    v[sel] = 1'b1;
    return v;
  endfunction

  // Next-state selection: disabled holds state, manual follows In, scan advances via the prescaler.
  always_comb begin
    pre_nxt_s  = pre_r;
    idx_nxt_s  = idx_r;
    out_nxt_s  = {LINES{1'b0}};
    wrap_nxt_s = 1'b0;
    if (!enable) begin
      pre_nxt_s  = pre_r;
      idx_nxt_s  = idx_r;
      out_nxt_s  = {LINES{1'b0}};
      wrap_nxt_s = 1'b0;
    end else if (!mode) begin
      pre_nxt_s  = {PW{1'b0}};
      idx_nxt_s  = In;
      out_nxt_s  = onehot(In);
      wrap_nxt_s = 1'b0;
    end else if (pre_r == PRE_LAST) begin
      pre_nxt_s  = {PW{1'b0}};
      idx_nxt_s  = idx_r + N'(1);
      wrap_nxt_s = (idx_r == IDX_LAST);
`ifdef DECODER_SCAN_DEADTIME_EN
      // Blank the step edge so the outgoing and incoming lines never overlap.
      out_nxt_s  = {LINES{1'b0}};
`else
      out_nxt_s  = onehot(idx_r + N'(1));
`endif
    end else begin
      pre_nxt_s  = pre_r + PW'(1);
      idx_nxt_s  = idx_r;
      out_nxt_s  = onehot(idx_r);
      wrap_nxt_s = 1'b0;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      pre_r  <= {PW{1'b0}};
      idx_r  <= {N{1'b0}};
      out_r  <= {LINES{1'b0}};
      wrap_r <= 1'b0;
    end else begin
      pre_r  <= pre_nxt_s;
      idx_r  <= idx_nxt_s;
      out_r  <= out_nxt_s;
      wrap_r <= wrap_nxt_s;
    end
  end

  assign Out   = out_r;
  assign index = idx_r;
  assign wrap  = wrap_r;

endmodule
